// File: rtl/phi_check_node_pkg.sv
// Shared types, constants and the phi table for the LDPC check-node slice.
// Compiled by every other file; optional min-sum mode is selected with CN_MINSUM_EN.
package ldpc_pkg;

  localparam int MAG_W      = 6;
  localparam int PHI_W      = 4;
  localparam int FRAC_SHIFT = 2;  // Q2.4 -> Q2.2

  typedef enum logic {
    ACCUM = 1'b0,
    EMIT  = 1'b1
  } cn_state_t;

  typedef struct packed {
    logic             sign;
    logic [MAG_W-1:0] mag;
  } msg_t;

  typedef struct packed {
    logic             sign;
    logic [PHI_W-1:0] mag;
  } cmsg_t;

  typedef struct packed {
    logic             sign;
    logic [PHI_W-1:0] phi;
  } edge_t;

  // f(x) = ln((1+e^-x)/(1-e^-x)), x = i/16, result rounded to quarters and capped at 15
  localparam logic [PHI_W-1:0] PHI_TABLE [64] = '{
    4'd15, 4'd14, 4'd11, 4'd9,  4'd8,  4'd7,  4'd7,  4'd6,
    4'd6,  4'd5,  4'd5,  4'd4,  4'd4,  4'd4,  4'd4,  4'd3,
    4'd3,  4'd3,  4'd3,  4'd3,  4'd2,  4'd2,  4'd2,  4'd2,
    4'd2,  4'd2,  4'd2,  4'd1,  4'd1,  4'd1,  4'd1,  4'd1,
    4'd1,  4'd1,  4'd1,  4'd1,  4'd1,  4'd1,  4'd1,  4'd1,
    4'd1,  4'd1,  4'd1,  4'd1,  4'd1,  4'd0,  4'd0,  4'd0,
    4'd0,  4'd0,  4'd0,  4'd0,  4'd0,  4'd0,  4'd0,  4'd0,
    4'd0,  4'd0,  4'd0,  4'd0,  4'd0,  4'd0,  4'd0,  4'd0
  };

  function automatic logic [PHI_W-1:0] minsum_mag(input logic [MAG_W-1:0] m);
    logic [MAG_W-1:0] q;
    q = m >> FRAC_SHIFT;
    return (q > MAG_W'(15)) ? 4'hF : q[PHI_W-1:0];
  endfunction

endpackage

// File: rtl/phi_check_node_if.sv
// Input and output message handshakes of the check-node processor.
// The block is the slave; the variable-node side / memory side is the master.
interface phi_check_node_if;
  import ldpc_pkg::*;

  logic  in_valid;
  logic  in_ready;
  msg_t  in_msg;
  logic  in_last;
  logic  out_valid;
  logic  out_ready;
  cmsg_t out_msg;
  logic  out_last;

  modport master (
    output in_valid, in_msg, in_last, out_ready,
    input  in_ready, out_valid, out_msg, out_last
  );

  modport slave (
    input  in_valid, in_msg, in_last, out_ready,
    output in_ready, out_valid, out_msg, out_last
  );

endinterface

// File: rtl/phi_check_node_phi_lut.sv
// Combinational Q2.4 -> Q2.2 phi lookup on the shared package table.
module phi_lut
  import ldpc_pkg::*;
(
  input  logic [MAG_W-1:0] i_idx,
  output logic [PHI_W-1:0] o_phi
);

  assign o_phi = PHI_TABLE[i_idx];

endmodule

// File: rtl/phi_check_node.sv
// Serial sum-product check node: accumulate phi/sign over the edges, then emit extrinsics.
// Define CN_MINSUM_EN to replace phi accumulation with min1/min2 tracking.
module phi_check_node
  import ldpc_pkg::*;
#(
  parameter int MAX_DEG = 8,
  parameter int CNT_W   = $clog2(MAX_DEG),
  parameter int SUM_W   = PHI_W + $clog2(MAX_DEG)
) (
  input  logic               clk,
  input  logic               rst_n,
  phi_check_node_if.slave    bus,
  output logic               deg_err
);

  localparam logic [CNT_W:0] CNT_ONE = (CNT_W+1)'(1);
  localparam logic [CNT_W:0] CNT_MAX = (CNT_W+1)'(MAX_DEG - 1);

  cn_state_t        r_state;
  logic [CNT_W:0]   r_count;
  logic [CNT_W:0]   r_idx;
  logic             r_parity;
  logic             r_in_ready;
  logic             r_out_valid;
  logic             r_out_last;
  logic             r_deg_err;
  cmsg_t            r_out_msg;
  edge_t            r_buf [MAX_DEG];

  logic             w_accept;
  logic             w_fire;
  logic             w_clear;
  logic             w_to_emit;
  logic             w_par_next;
  logic             w_out_sign;
  logic [CNT_W:0]   w_idx_next;
  edge_t            w_in_edge;
  edge_t            w_sel_edge;
  logic [PHI_W-1:0] w_out_mag;

  assign w_accept   = bus.in_valid & r_in_ready;
  assign w_fire     = r_out_valid & bus.out_ready;
  assign w_clear    = w_fire & r_out_last;
  assign w_to_emit  = w_accept & (bus.in_last | (r_count == CNT_MAX));
  assign w_par_next = r_parity ^ bus.in_msg.sign;
  assign w_idx_next = r_idx + CNT_ONE;

  // The first output is built while the final edge is still arriving, so edge 0 may
  // not be in the buffer yet (degree 1) and the running totals are taken pre-register.
  assign w_sel_edge = (r_state == EMIT) ? r_buf[w_idx_next[CNT_W-1:0]]
                    : ((r_count == '0) ? w_in_edge : r_buf[0]);
  assign w_out_sign = ((r_state == EMIT) ? r_parity : w_par_next) ^ w_sel_edge.sign;

`ifdef CN_MINSUM_EN
  logic [MAG_W-1:0] r_min1, r_min2;
  logic [CNT_W-1:0] r_min1_idx;
  logic [MAG_W-1:0] w_min1_next, w_min2_next, w_min1_sel, w_min2_sel;
  logic [CNT_W-1:0] w_min1_idx_next, w_min1_idx_sel, w_sel_idx;
  logic             w_new_min1, w_new_min2;

  assign w_in_edge       = {bus.in_msg.sign, {PHI_W{1'b0}}};
  assign w_new_min1      = bus.in_msg.mag < r_min1;
  assign w_new_min2      = bus.in_msg.mag < r_min2;
  assign w_min1_next     = w_new_min1 ? bus.in_msg.mag : r_min1;
  assign w_min2_next     = w_new_min1 ? r_min1 : (w_new_min2 ? bus.in_msg.mag : r_min2);
  assign w_min1_idx_next = w_new_min1 ? r_count[CNT_W-1:0] : r_min1_idx;

  assign w_min1_sel      = (r_state == EMIT) ? r_min1 : w_min1_next;
  assign w_min2_sel      = (r_state == EMIT) ? r_min2 : w_min2_next;
  assign w_min1_idx_sel  = (r_state == EMIT) ? r_min1_idx : w_min1_idx_next;
  assign w_sel_idx       = (r_state == EMIT) ? w_idx_next[CNT_W-1:0] : '0;
  assign w_out_mag       = minsum_mag((w_sel_idx == w_min1_idx_sel) ? w_min2_sel : w_min1_sel);

  always_ff @(posedge clk) begin
    if (!rst_n || w_clear) begin
      r_min1     <= '1;
      r_min2     <= '1;
      r_min1_idx <= '0;
    end else if (w_accept) begin
      r_min1     <= w_min1_next;
      r_min2     <= w_min2_next;
      r_min1_idx <= w_min1_idx_next;
    end
  end
`else
  localparam logic [SUM_W-1:0] DIFF_SAT = SUM_W'(1 << (MAG_W - FRAC_SHIFT));

  logic [SUM_W-1:0] r_s, w_s_next, w_diff;
  logic [PHI_W-1:0] w_in_phi;
  logic [MAG_W-1:0] w_p2_idx;

  phi_lut u_phi1 (.i_idx(bus.in_msg.mag), .o_phi(w_in_phi));

  assign w_in_edge = {bus.in_msg.sign, w_in_phi};
  assign w_s_next  = r_s + SUM_W'(w_in_phi);
  assign w_diff    = ((r_state == EMIT) ? r_s : w_s_next) - SUM_W'(w_sel_edge.phi);
  // Shifting the Q2.2 difference back to Q2.4 clamps at the top table entry
  assign w_p2_idx  = (w_diff >= DIFF_SAT) ? '1
                   : {w_diff[MAG_W-FRAC_SHIFT-1:0], {FRAC_SHIFT{1'b0}}};

  phi_lut u_phi2 (.i_idx(w_p2_idx), .o_phi(w_out_mag));

  always_ff @(posedge clk) begin
    if (!rst_n || w_clear) begin
      r_s <= '0;
    end else if (w_accept) begin
      r_s <= w_s_next;
    end
  end
`endif

  // Small edge store read asynchronously so the next output can be registered on accept
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_buf[r_count[CNT_W-1:0]] <= w_in_edge;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ACCUM;
      r_count     <= '0;
      r_idx       <= '0;
      r_parity    <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_out_msg   <= '0;
      r_out_last  <= 1'b0;
      r_deg_err   <= 1'b0;
    end else begin
      case (r_state)
        ACCUM: begin
          if (w_accept) begin
            r_count  <= r_count + CNT_ONE;
            r_parity <= w_par_next;
            if (w_to_emit) begin
              r_state     <= EMIT;
              r_idx       <= '0;
              r_in_ready  <= 1'b0;
              r_out_valid <= 1'b1;
              r_out_msg   <= {w_out_sign, w_out_mag};
              r_out_last  <= (r_count == '0);
              if (!bus.in_last) begin
                r_deg_err <= 1'b1;
              end
            end
          end
        end
        EMIT: begin
          if (w_fire) begin
            if (r_out_last) begin
              r_state     <= ACCUM;
              r_count     <= '0;
              r_idx       <= '0;
              r_parity    <= 1'b0;
              r_in_ready  <= 1'b1;
              r_out_valid <= 1'b0;
              r_out_msg   <= '0;
              r_out_last  <= 1'b0;
            end else begin
              r_idx       <= w_idx_next;
              r_out_msg   <= {w_out_sign, w_out_mag};
              r_out_last  <= (w_idx_next == r_count - CNT_ONE);
            end
          end
        end
        default: r_state <= ACCUM;
      endcase
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_msg   = r_out_msg;
  assign bus.out_last  = r_out_last;
  assign deg_err       = r_deg_err;

endmodule

// File: tb/tb_phi_check_node.sv
// Directed bench for phi_check_node; inputs driven and outputs sampled on the falling edge.
// Build with CN_MINSUM_EN defined to exercise the min-sum variant instead.
module tb_phi_check_node;
  import ldpc_pkg::*;

  localparam int LIMIT = 50;

  logic clk = 1'b0;
  logic rst_n;
  logic deg_err;
  int   n_checks = 0;
  int   n_pass   = 0;
  int   n_fail   = 0;

  phi_check_node_if bus ();

  phi_check_node #(.MAX_DEG(8)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .deg_err (deg_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called and returns at a falling edge; the message is taken on the enclosed rising edge.
  task automatic send(input logic s, input logic [MAG_W-1:0] m, input logic last);
    int n;
    n = 0;
    bus.in_valid = 1'b1;
    bus.in_msg   = {s, m};
    bus.in_last  = last;
    while (!bus.in_ready && n < LIMIT) begin
      @(negedge clk);
      n++;
    end
    if (n >= LIMIT) chk("in_ready_timeout", 32'(bus.in_ready), 32'd1);
    $display("tx sign=%b mag=%0d last=%b", s, m, last);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic recv(input string tag, input logic [4:0] exp_msg, input logic exp_last);
    int n;
    n = 0;
    bus.out_ready = 1'b1;
    while (!bus.out_valid && n < LIMIT) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
    chk({tag, "_msg"},   32'(bus.out_msg),   32'(exp_msg));
    chk({tag, "_last"},  32'(bus.out_last),  32'(exp_last));
    $display("rx %s msg=0x%02h last=%b", tag, bus.out_msg, bus.out_last);
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_msg    = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;
    rst_n         = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready",  32'(bus.in_ready),  32'd1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_msg",   32'(bus.out_msg),   32'd0);
    chk("rst_out_last",  32'(bus.out_last),  32'd0);
    chk("rst_deg_err",   32'(deg_err),       32'd0);
    rst_n = 1'b1;

`ifdef CN_MINSUM_EN
    // min1 = 8 at edge 2, min2 = 16
    send(1'b0, 6'd16, 1'b0);
    send(1'b0, 6'd32, 1'b0);
    send(1'b0, 6'd8,  1'b1);
    recv("ms_e0", 5'h02, 1'b0);
    recv("ms_e1", 5'h02, 1'b0);
    recv("ms_e2", 5'h04, 1'b1);
    chk("ms_done_valid", 32'(bus.out_valid), 32'd0);
    chk("ms_in_ready",   32'(bus.in_ready),  32'd1);
`else
    // Degree 3: +1,+1,-1 -> S = 9, each diff 6 -> phi 2; signs 1,1,0
    send(1'b0, 6'd16, 1'b0);
    send(1'b0, 6'd16, 1'b0);
    send(1'b1, 6'd16, 1'b1);
    chk("d3_latency_valid", 32'(bus.out_valid), 32'd1);
    chk("d3_in_ready_low",  32'(bus.in_ready),  32'd0);
    recv("d3_e0", 5'h12, 1'b0);
    recv("d3_e1", 5'h12, 1'b0);
    for (int k = 0; k < 3; k++) begin
      chk("bp_valid",    32'(bus.out_valid), 32'd1);
      chk("bp_msg",      32'(bus.out_msg),   32'h02);
      chk("bp_last",     32'(bus.out_last),  32'd1);
      chk("bp_in_ready", 32'(bus.in_ready),  32'd0);
      @(negedge clk);
    end
    recv("d3_e2", 5'h02, 1'b1);
    chk("d3_done_valid", 32'(bus.out_valid), 32'd0);
    chk("d3_in_ready",   32'(bus.in_ready),  32'd1);

    // Degree 1: diff 0 -> magnitude 15
    send(1'b0, 6'd4, 1'b1);
    recv("d1", 5'h0F, 1'b1);
    chk("d1_deg_err", 32'(deg_err), 32'd0);

    // Degree 2, zero magnitudes: S = 30, diff 15 -> index 60 -> 0
    send(1'b0, 6'd0, 1'b0);
    send(1'b1, 6'd0, 1'b1);
    recv("d2_e0", 5'h10, 1'b0);
    recv("d2_e1", 5'h00, 1'b1);

    // Overflow: phi 3, 8, then six zeros -> S = 11; diffs 8, 3, 11 -> 1, 4, 1
    send(1'b1, 6'd16, 1'b0);
    send(1'b0, 6'd4,  1'b0);
    for (int k = 0; k < 6; k++) send(1'b0, 6'd63, 1'b0);
    chk("ovf_deg_err", 32'(deg_err), 32'd1);
    recv("ovf_e0", 5'h01, 1'b0);
    recv("ovf_e1", 5'h14, 1'b0);
    for (int k = 2; k < 8; k++) recv($sformatf("ovf_e%0d", k), 5'h11, (k == 7));
    chk("ovf_done_valid", 32'(bus.out_valid), 32'd0);
    send(1'b1, 6'd63, 1'b1);
    recv("post_ovf", 5'h0F, 1'b1);
    chk("deg_err_sticky", 32'(deg_err), 32'd1);

    // Reset after the first output of a degree-3 node
    send(1'b0, 6'd16, 1'b0);
    send(1'b0, 6'd16, 1'b0);
    send(1'b1, 6'd16, 1'b1);
    recv("rst_e0", 5'h12, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("mid_rst_in_ready",  32'(bus.in_ready),  32'd1);
    chk("mid_rst_deg_err",   32'(deg_err),       32'd0);
    rst_n = 1'b1;
    // Fresh node: phi 3 and 8 -> S = 11; diffs 8, 3 -> 1, 4
    send(1'b0, 6'd16, 1'b0);
    send(1'b0, 6'd4,  1'b1);
    recv("fresh_e0", 5'h01, 1'b0);
    recv("fresh_e1", 5'h04, 1'b1);
    chk("fresh_done_valid", 32'(bus.out_valid), 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
